mem_wr_arbiter: RTL and testbench
=================================

MEM_WR_ARBITER -- requirements
Module: mem_wr_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- N_ELEMENTS, 128, memory depth in words
- ADDR_WIDTH, 16, address width in bits
- DATA_WIDTH, 16, data width in bits
- N_REQ, 3, number of write requesters (2..8)

REQ-002 SHALL have ports, one per line:
- clk  in  1  clock; all logic on posedge clk
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester write request
- req_addr  in  N_REQ*ADDR_WIDTH  per-requester address; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  in  N_REQ*DATA_WIDTH  per-requester data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  N_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high
- clr_start  in  1  single-cycle pulse that starts a clear sweep
- clr_busy  out  1  high while a clear sweep runs
- clr_done  out  1  single-cycle pulse after the last clear write
- w_addr  out  ADDR_WIDTH  memory write address
- w_data  out  DATA_WIDTH  memory write data
- w_en  out  1  memory write enable
- addr_err  out  1  single-cycle pulse for an accepted out-of-range request

Function
REQ-003 SHALL implement states IDLE (arbitrate) and CLEAR.
REQ-004 In IDLE, SHALL grant at most one requester per cycle, round-robin:
- search begins at pointer rr_ptr and wraps modulo N_REQ;
- req_ready is combinational from req_valid and rr_ptr;
- req_ready[i] is never high unless req_valid[i] is high.
REQ-005 On a transfer by requester i, rr_ptr SHALL become (i+1) mod N_REQ; with no transfer, rr_ptr SHALL hold.
REQ-006 w_addr, w_data and w_en SHALL be registered: exactly one cycle of latency from the transfer cycle to w_en=1.
REQ-007 A requester SHALL hold req_valid, req_addr and req_data stable until its transfer; the block does not depend on early deassertion.
REQ-008 An accepted request with req_addr >= N_ELEMENTS SHALL:
- be consumed (ready asserted);
- produce w_en=0;
- pulse addr_err in the cycle w_en would have been asserted.
REQ-009 With no transfer, w_en SHALL be 0 the following cycle; w_addr and w_data SHALL hold their last values.
REQ-010 clr_start in IDLE SHALL enter CLEAR the next cycle; any transfer in the same cycle as clr_start SHALL still complete.
REQ-011 In CLEAR:
- req_ready SHALL be all 0;
- w_en=1 and w_data=0 every cycle;
- w_addr SHALL step 0,1,...,N_ELEMENTS-1, one per cycle.
REQ-012 After the write to N_ELEMENTS-1, SHALL return to IDLE and pulse clr_done in the cycle after that write; clr_busy SHALL be high for exactly N_ELEMENTS cycles.
REQ-013 clr_start during CLEAR SHALL be ignored; the sweep is not restarted.
REQ-014 After CLEAR, rr_ptr SHALL keep its pre-clear value; pending requests are then served in round-robin order.

Reset
REQ-015 rst SHALL asynchronously force all of the following; operation resumes on the first posedge after rst falls:
- state=IDLE
- rr_ptr=0
- w_en=0, w_addr=0, w_data=0
- clr_busy=0, clr_done=0, addr_err=0
REQ-016 rst asserted mid-CLEAR SHALL abort the sweep with no clr_done pulse.

Configuration
REQ-017 Macro MEM_CLEAR_EN:
- defined: the CLEAR state and sweep counter SHALL be compiled in;
- undefined: clr_start SHALL be ignored, clr_busy and clr_done SHALL be tied 0, the block stays in IDLE, and the port list is unchanged.

Structure
REQ-018 Package mem_arb_pkg SHALL hold the state type (IDLE, CLEAR) and the default N_REQ constant.
REQ-019 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; output: one-hot grant).

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Single requester 0, addr=5, data=0xBEEF: ready in the same cycle; next cycle w_en=1, w_addr=5, w_data=0xBEEF.
- All three valid continuously from reset: grants in order 0,1,2,0,... with one w_en per cycle and no gaps.
- Requester 1 at addr=200 (N_ELEMENTS=128): accepted, w_en=0, addr_err pulses once.
- clr_start with requester 2 valid: CLEAR writes addresses 0..127 with data 0 over 128 cycles; req_ready=0 throughout; then clr_done pulses and requester 2 is granted in the next IDLE cycle.
- rst asserted at sweep address 40: outputs go to 0 immediately; no clr_done; rr_ptr=0.
- MEM_CLEAR_EN undefined: clr_start has no effect; arbitration is unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory write arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEF_N_REQ = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant
);

  always_comb begin
    int               t;
    logic [PTR_W-1:0] idx;
    logic             found;
    o_grant = '0;
    found   = 1'b0;
    t       = 0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      t = int'(i_ptr) + k;
      if (t >= N_REQ) t = t - N_REQ;
      idx = PTR_W'(t);
      if (!found && i_req[idx]) begin
        o_grant[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_wr_arbiter.sv
// Round-robin write arbiter into a single memory port with optional clear sweep.
// The CLEAR state and sweep counter exist only when MEM_CLEAR_EN is defined.
module mem_wr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_ELEMENTS = 128,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int N_REQ      = DEF_N_REQ
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        clr_start,
  output logic                        clr_busy,
  output logic                        clr_done,
  output logic [ADDR_WIDTH-1:0]       w_addr,
  output logic [DATA_WIDTH-1:0]       w_data,
  output logic                        w_en,
  output logic                        addr_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_w_en;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic                  r_addr_err;

  logic [N_REQ-1:0]      w_grant;
  logic [PTR_W-1:0]      w_sel;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_xfer;
  logic                  w_addr_ok;
  logic [PTR_W-1:0]      w_next_ptr;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign w_xfer    = |req_ready;

  always_comb begin
    w_sel      = '0;
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel      = PTR_W'(i);
        w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_addr_ok  = (64'(w_sel_addr) < 64'(N_ELEMENTS));
  assign w_next_ptr = (w_sel == PTR_W'(N_REQ - 1)) ? '0 : w_sel + 1'b1;

  assign w_en     = r_w_en;
  assign w_addr   = r_w_addr;
  assign w_data   = r_w_data;
  assign addr_err = r_addr_err;

`ifdef MEM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic                  r_clr_busy;
  logic                  r_clr_done;

  assign clr_busy = r_clr_busy;
  assign clr_done = r_clr_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_w_en     <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
      r_addr_err <= 1'b0;
      r_clr_cnt  <= '0;
      r_clr_busy <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_w_en     <= 1'b0;
      r_addr_err <= 1'b0;
      r_clr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_rr_ptr <= w_next_ptr;
            if (w_addr_ok) begin
              r_w_en   <= 1'b1;
              r_w_addr <= w_sel_addr;
              r_w_data <= w_sel_data;
            end else begin
              r_addr_err <= 1'b1;
            end
          end
          // A transfer accepted alongside clr_start is written before the sweep begins.
          if (clr_start) begin
            r_state    <= CLEAR;
            r_clr_cnt  <= '0;
            r_clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          r_w_en    <= 1'b1;
          r_w_addr  <= r_clr_cnt;
          r_w_data  <= '0;
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == ADDR_WIDTH'(N_ELEMENTS - 1)) begin
            r_state    <= IDLE;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  logic w_unused_clr_start;

  assign w_unused_clr_start = clr_start;
  assign clr_busy           = 1'b0;
  assign clr_done           = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_w_en     <= 1'b0;
      r_w_addr   <= '0;
      r_w_data   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= IDLE;
      r_w_en     <= 1'b0;
      r_addr_err <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr <= w_next_ptr;
        if (w_addr_ok) begin
          r_w_en   <= 1'b1;
          r_w_addr <= w_sel_addr;
          r_w_data <= w_sel_data;
        end else begin
          r_addr_err <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Directed bench for mem_wr_arbiter; clear-sweep scenarios depend on MEM_CLEAR_EN.
module tb_mem_wr_arbiter;

  localparam int N_ELEMENTS = 128;
  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int N_REQ      = 3;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        clr_start;
  logic                        clr_busy;
  logic                        clr_done;
  logic [ADDR_WIDTH-1:0]       w_addr;
  logic [DATA_WIDTH-1:0]       w_data;
  logic                        w_en;
  logic                        addr_err;

  int n_checks = 0;
  int n_errs   = 0;

  mem_wr_arbiter #(
    .N_ELEMENTS (N_ELEMENTS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .N_REQ      (N_REQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .w_en      (w_en),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] d);
    req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  initial begin
    logic found;
    logic saw_done;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    clr_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_w_en", w_en, 0);
    chk_val("rst_w_addr", w_addr, 0);
    chk_val("rst_w_data", w_data, 0);
    chk_val("rst_busy", clr_busy, 0);
    chk_val("rst_done", clr_done, 0);
    chk_val("rst_addr_err", addr_err, 0);
    chk_val("rst_ready", req_ready, 0);
    rst = 1'b0;

    // All three valid from reset: grants 0,1,2,0,1,2 back to back.
    for (int i = 0; i < N_REQ; i++) set_req(i, 16'(10 + i), 16'(16'h100 + i));
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk_val($sformatf("rr_ready_%0d", k), req_ready, 32'(1 << (k % 3)));
      if (k > 0) begin
        chk_val($sformatf("rr_w_en_%0d", k), w_en, 1);
        chk_val($sformatf("rr_w_addr_%0d", k), w_addr, 32'(10 + (k - 1) % 3));
      end
      tick();
    end
    req_valid = '0;
    #1;
    chk_val("rr_last_w_en", w_en, 1);
    chk_val("rr_last_w_addr", w_addr, 12);
    chk_val("rr_last_w_data", w_data, 32'h102);
    tick();
    chk_val("idle_w_en", w_en, 0);
    chk_val("idle_w_addr_hold", w_addr, 12);
    chk_val("idle_w_data_hold", w_data, 32'h102);

    // Single requester 0.
    set_req(0, 16'd5, 16'hBEEF);
    req_valid = 3'b001;
    #1;
    chk_val("single_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    chk_val("single_w_en", w_en, 1);
    chk_val("single_w_addr", w_addr, 5);
    chk_val("single_w_data", w_data, 32'hBEEF);
    chk_val("single_addr_err", addr_err, 0);

    // Out-of-range request on requester 1.
    set_req(1, 16'd200, 16'h1234);
    req_valid = 3'b010;
    #1;
    chk_val("err_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    chk_val("err_w_en", w_en, 0);
    chk_val("err_pulse", addr_err, 1);
    chk_val("err_w_addr_hold", w_addr, 5);
    tick();
    chk_val("err_pulse_end", addr_err, 0);

    // Pointer at 2 wraps to 0; addresses 127 and 128 straddle the limit.
    set_req(0, 16'd127, 16'h7777);
    set_req(1, 16'd128, 16'h8888);
    req_valid = 3'b011;
    #1;
    chk_val("wrap_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b010;
    #1;
    chk_val("edge127_w_en", w_en, 1);
    chk_val("edge127_w_addr", w_addr, 127);
    chk_val("edge127_w_data", w_data, 32'h7777);
    chk_val("edge128_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
    chk_val("edge128_w_en", w_en, 0);
    chk_val("edge128_err", addr_err, 1);

    set_req(2, 16'd7, 16'hAAAA);
    req_valid = 3'b100;
    #1;
    chk_val("req2_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    #1;
    chk_val("req2_w_addr", w_addr, 7);

`ifdef MEM_CLEAR_EN
    // Clear sweep; the requester-0 transfer in the clr_start cycle still lands.
    set_req(0, 16'd3, 16'h3333);
    req_valid = 3'b101;
    clr_start = 1'b1;
    #1;
    chk_val("clr_start_ready", req_ready, 3'b001);
    tick();
    clr_start = 1'b0;
    req_valid = 3'b100;
    #1;
    chk_val("clr_xfer_w_en", w_en, 1);
    chk_val("clr_xfer_w_addr", w_addr, 3);
    chk_val("clr_xfer_w_data", w_data, 32'h3333);
    chk_val("clr_busy_start", clr_busy, 1);
    chk_val("clr_ready_start", req_ready, 0);
    for (int k = 0; k < N_ELEMENTS; k++) begin
      clr_start = (k == 60);
      tick();
      chk_val($sformatf("clr_w_en_%0d", k), w_en, 1);
      chk_val($sformatf("clr_w_addr_%0d", k), w_addr, 32'(k));
      chk_val($sformatf("clr_w_data_%0d", k), w_data, 0);
      if (k < N_ELEMENTS - 1) begin
        chk_val($sformatf("clr_busy_%0d", k), clr_busy, 1);
        chk_val($sformatf("clr_done_%0d", k), clr_done, 0);
        chk_val($sformatf("clr_ready_%0d", k), req_ready, 0);
      end else begin
        chk_val("clr_busy_end", clr_busy, 0);
        chk_val("clr_done_pulse", clr_done, 1);
        chk_val("clr_after_ready", req_ready, 3'b100);
      end
    end
    clr_start = 1'b0;
    tick();
    req_valid = '0;
    #1;
    chk_val("post_clr_w_en", w_en, 1);
    chk_val("post_clr_w_addr", w_addr, 7);
    chk_val("post_clr_w_data", w_data, 32'hAAAA);
    chk_val("post_clr_done_end", clr_done, 0);

    // Move pointer off 0, then reset in the middle of a sweep.
    set_req(0, 16'd1, 16'h0001);
    req_valid = 3'b001;
    #1;
    tick();
    req_valid = '0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (w_en && w_addr == 16'd40) found = 1'b1;
      else tick();
    end
    chk_val("abort_reached_40", found, 1);
    #1;
    rst = 1'b1;
    #1;
    chk_val("abort_w_en", w_en, 0);
    chk_val("abort_w_addr", w_addr, 0);
    chk_val("abort_w_data", w_data, 0);
    chk_val("abort_busy", clr_busy, 0);
    chk_val("abort_done", clr_done, 0);
    tick();
    rst = 1'b0;
    req_valid = 3'b111;
    #1;
    chk_val("abort_rr_ptr0", req_ready, 3'b001);
    tick();
    req_valid = '0;
    saw_done = 1'b0;
    for (int c = 0; c < 140; c++) begin
      if (clr_done || clr_busy) saw_done = 1'b1;
      tick();
    end
    chk_val("abort_no_done", saw_done, 0);
`else
    // Without the clear feature, clr_start must not disturb arbitration.
    set_req(0, 16'd3, 16'h3333);
    req_valid = 3'b101;
    clr_start = 1'b1;
    #1;
    chk_val("noclr_ready0", req_ready, 3'b001);
    tick();
    clr_start = 1'b0;
    #1;
    chk_val("noclr_busy", clr_busy, 0);
    chk_val("noclr_ready1", req_ready, 3'b100);
    chk_val("noclr_w_addr0", w_addr, 3);
    tick();
    req_valid = '0;
    #1;
    chk_val("noclr_w_en1", w_en, 1);
    chk_val("noclr_w_addr1", w_addr, 7);
    chk_val("noclr_w_data1", w_data, 32'hAAAA);
    chk_val("noclr_done", clr_done, 0);
    rst = 1'b1;
    #1;
    chk_val("async_rst_w_en", w_en, 0);
    chk_val("async_rst_w_addr", w_addr, 0);
    tick();
    rst = 1'b0;
    req_valid = 3'b110;
    #1;
    chk_val("async_rst_ptr", req_ready, 3'b010);
    tick();
    req_valid = '0;
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
